// File: rtl/in_channel_feeder_if.sv
// Host/machine-facing signal bundle for in_channel_feeder: load handshake,
// seal pulse, in-instruction request and the popped-word / status outputs.
interface in_channel_feeder_if #(
  parameter int W = 12
);
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         seal;
  logic         in_req;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_miss;
  logic [W-1:0] size;
  logic [1:0]   state;

  modport master (
    output load_valid, load_data, seal, in_req,
    input  load_ready, in_valid, in_data, in_miss, size, state
  );

  modport slave (
    input  load_valid, load_data, seal, in_req,
    output load_ready, in_valid, in_data, in_miss, size, state
  );
endinterface

// File: rtl/in_channel_feeder.sv
// Input-channel feeder: a circular word buffer filled by the host and drained
// one word per in instruction, sequenced by a FILL/SERVE/DONE state machine.
module in_channel_feeder #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  in_channel_feeder_if.slave   bus
);
  localparam int PTR_W = (NIn > 1) ? $clog2(NIn) : 1;
  localparam logic [PTR_W-1:0]              LAST  = PTR_W'(NIn - 1);
  localparam logic [MemoryElementWidth-1:0] DEPTH = MemoryElementWidth'(NIn);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                        st, st_nxt;
  logic [MemoryElementWidth-1:0] mem [NIn];
  logic [PTR_W-1:0]              rd_ptr, wr_ptr;
  logic [MemoryElementWidth-1:0] count, count_nxt;
  logic [MemoryElementWidth-1:0] in_data_q;
  logic                          in_valid_q, in_miss_q;
  logic                          load_ok, do_load, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    load_ok   = (st == FILL) && (count < DEPTH);
    do_load   = bus.load_valid && load_ok;
    do_pop    = bus.in_req && (count != '0);
    count_nxt = count;
    case ({do_load, do_pop})
      2'b10:   count_nxt = count + MemoryElementWidth'(1);
      2'b01:   count_nxt = count - MemoryElementWidth'(1);
      default: count_nxt = count;
    endcase
  end

  // Seal takes effect after any same-cycle load; DONE only re-arms on a host
  // offer, and that offered word is refused since load_ready is low in DONE.
  always_comb begin
    st_nxt = st;
    case (st)
      FILL:    if (bus.seal)          st_nxt = SERVE;
      SERVE:   if (count_nxt == '0)   st_nxt = DONE;
      DONE:    if (bus.load_valid)    st_nxt = FILL;
      default:                        st_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= FILL;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      in_miss_q  <= 1'b0;
    end else begin
      st         <= st_nxt;
      count      <= count_nxt;
      in_valid_q <= do_pop;
      in_miss_q  <= bus.in_req && !do_pop;
      if (do_load) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        in_data_q <= mem[rd_ptr];
      end
    end
  end

  // Storage carries no reset; a pop only ever reads words written earlier.
  always_ff @(posedge clock) begin
    if (do_load && !reset) mem[wr_ptr] <= bus.load_data;
  end

  assign bus.load_ready = load_ok;
  assign bus.in_valid   = in_valid_q;
  assign bus.in_miss    = in_miss_q;
  assign bus.in_data    = in_data_q;
  assign bus.size       = count;
  assign bus.state      = st;
endmodule

// File: tb/tb_in_channel_feeder.sv
// Directed bench for in_channel_feeder: a cycle-by-cycle vector table plus
// hand-written full-buffer and pointer-wrap sequences.
module tb_in_channel_feeder;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  in_channel_feeder_if #(.W(12)) bus ();

  in_channel_feeder #(.MemoryElementWidth(12), .NIn(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, lv;
    logic [11:0] ld;
    logic        seal, req;
    logic        lr, iv;
    logic [11:0] id;
    logic        im;
    logic [11:0] sz;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input logic r, lv, input int ld, input logic s, q,
                               input logic lr, iv, input int id, input logic im,
                               input int sz, input int st);
    vec_t v;
    v.rst = r; v.lv = lv; v.ld = 12'(ld); v.seal = s; v.req = q;
    v.lr = lr; v.iv = iv; v.id = 12'(id); v.im = im; v.sz = 12'(sz); v.st = 2'(st);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else passed++;
  endtask

  task automatic cyc(input logic r, lv, input int d, input logic s, q);
    rst = r; bus.load_valid = lv; bus.load_data = 12'(d); bus.seal = s; bus.in_req = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.load_valid = 1'b0; bus.load_data = '0; bus.seal = 1'b0; bus.in_req = 1'b0;
    //    rst lv  ld  seal req | lr iv  id  im  sz st
    addv(1, 0,  0, 0, 0,   1, 0,  0, 0, 0, 0);  // reset state
    addv(0, 1, 88, 0, 0,   1, 0,  0, 0, 1, 0);
    addv(0, 1, 44, 0, 0,   1, 0,  0, 0, 2, 0);
    addv(0, 0,  0, 1, 0,   0, 0,  0, 0, 2, 1);  // seal -> SERVE
    addv(0, 0,  0, 0, 1,   0, 1, 88, 0, 1, 1);
    addv(0, 0,  0, 0, 1,   0, 1, 44, 0, 0, 2);  // drained -> DONE
    addv(0, 0,  0, 0, 1,   0, 0, 44, 1, 0, 2);  // miss, in_data held
    addv(0, 0,  0, 0, 0,   0, 0, 44, 0, 0, 2);
    addv(0, 1,  5, 0, 0,   1, 0, 44, 0, 0, 0);  // DONE->FILL, word 5 refused
    addv(0, 1,  7, 1, 0,   0, 0, 44, 0, 1, 1);  // load + seal same cycle
    addv(0, 0,  0, 0, 1,   0, 1,  7, 0, 0, 2);
    addv(0, 0,  0, 0, 0,   0, 0,  7, 0, 0, 2);
    addv(0, 1,  1, 0, 0,   1, 0,  7, 0, 0, 0);
    addv(0, 1,  1, 0, 0,   1, 0,  7, 0, 1, 0);
    addv(0, 1,  2, 0, 0,   1, 0,  7, 0, 2, 0);
    addv(0, 1,  3, 0, 0,   1, 0,  7, 0, 3, 0);
    addv(0, 1,  4, 0, 0,   1, 0,  7, 0, 4, 0);
    addv(0, 1,  5, 0, 0,   1, 0,  7, 0, 5, 0);
    addv(1, 1,  9, 1, 1,   1, 0,  0, 0, 0, 0);  // reset mid-run overrides all
    addv(0, 0,  0, 0, 1,   1, 0,  0, 1, 0, 0);
    addv(0, 0,  0, 0, 0,   1, 0,  0, 0, 0, 0);
    addv(0, 0,  0, 1, 0,   0, 0,  0, 0, 0, 1);  // seal with empty buffer
    addv(0, 0,  0, 0, 0,   0, 0,  0, 0, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].lv, int'(tbl[i].ld), tbl[i].seal, tbl[i].req);
      chk($sformatf("v%0d.load_ready", i), 32'(bus.load_ready), 32'(tbl[i].lr));
      chk($sformatf("v%0d.in_valid", i),   32'(bus.in_valid),   32'(tbl[i].iv));
      chk($sformatf("v%0d.in_data", i),    32'(bus.in_data),    32'(tbl[i].id));
      chk($sformatf("v%0d.in_miss", i),    32'(bus.in_miss),    32'(tbl[i].im));
      chk($sformatf("v%0d.size", i),       32'(bus.size),       32'(tbl[i].sz));
      chk($sformatf("v%0d.state", i),      32'(bus.state),      32'(tbl[i].st));
    end

    // Full buffer: ninth word must be held off, then drain in order
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 10 + i, 0, 0);
      chk($sformatf("full.size%0d", i), 32'(bus.size), 32'(i + 1));
    end
    chk("full.load_ready", 32'(bus.load_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 99, 0, 0);
      chk($sformatf("held.size%0d", i), 32'(bus.size), 32'd8);
      chk($sformatf("held.load_ready%0d", i), 32'(bus.load_ready), 32'd0);
    end
    cyc(0, 1, 99, 0, 1);
    chk("full.pop_valid", 32'(bus.in_valid), 32'd1);
    chk("full.pop_data", 32'(bus.in_data), 32'd10);
    chk("full.pop_size", 32'(bus.size), 32'd7);
    chk("full.pop_ready", 32'(bus.load_ready), 32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("drain.data%0d", i), 32'(bus.in_data), 32'(11 + i));
    end
    cyc(0, 0, 0, 0, 1);
    chk("drain.miss", 32'(bus.in_miss), 32'd1);
    chk("drain.data_held", 32'(bus.in_data), 32'd17);

    // Streaming in FILL at count=3 with write pointer wrapping 7 -> 0
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1 + i, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap.pre1", 32'(bus.in_data), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("wrap.pre2", 32'(bus.in_data), 32'd2);
    chk("wrap.size3", 32'(bus.size), 32'd3);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 6 + i, 0, 1);
      chk($sformatf("wrap.size%0d", i), 32'(bus.size), 32'd3);
      chk($sformatf("wrap.valid%0d", i), 32'(bus.in_valid), 32'd1);
      chk($sformatf("wrap.data%0d", i), 32'(bus.in_data), 32'(3 + i));
    end
    chk("wrap.state", 32'(bus.state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("wrap.tail%0d", i), 32'(bus.in_data), 32'(9 + i));
    end
    chk("wrap.empty", 32'(bus.size), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
